csoc_scan_loader: RTL
=====================

// Module: csoc_scan_loader
// PURPOSE
//  Host-to-CSOC direction of the serial test link. Consumes UART RX bytes, decodes ASCII commands,
//  shifts a host-supplied bit image into the CSOC scan chain ('0'/'1' chars) and issues functional
//  run clocks. Sits between the UART receiver and the CSOC test pins; the scan-out dump stays in the
//  TX-side command parser.
// PARAMETERS
//  CSOC_NREGS   1919  scan chain length; bits shifted per 'L' command
//  RUN_CLKS     10    functional csoc_clk pulses per 'R' command
//  HALF_PERIOD  4     clk cycles csoc_clk_o stays high, and then low, per pulse (>=1)
//  TIMEOUT_CYC  1_000_000  idle-byte limit during load (used only with CSOC_SCAN_TIMEOUT_EN)
// PORTS
//  clk            in   1  system clock
//  rstn           in   1  synchronous reset, active low
//  rx_data        in   8  byte from UART receiver
//  new_rx_data    in   1  1-cycle strobe, rx_data valid
//  csoc_clk_o     out  1  CSOC clock (generated, registered)
//  csoc_test_se_o out  1  scan enable
//  csoc_test_tm_o out  1  test mode
//  csoc_data_o    out  8  bit 0 = scan-in bit, bits 7:1 = 0
//  busy_o         out  1  1 in any state except IDLE and ERROR
//  done_o         out  1  1-cycle pulse when a load or run completes
//  error_o        out  1  sticky while in ERROR
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; bit/clock counters 0. Reset mid-shift drops csoc_clk_o low on
//   the next edge; no partial pulse is completed.
//  States: IDLE, LOAD_WAIT, SETUP, CLK_HI, CLK_LO, RUN_HI, RUN_LO, ERROR.
//  IDLE: on strobe, 'L' -> LOAD_WAIT, se=1, tm=1, bit_cnt=0; 'R' -> RUN_HI, se=0, tm=1, clk_cnt=0;
//   other bytes ignored.
//  LOAD_WAIT: strobe with '0'/'1' -> csoc_data_o[0] registered from the char, then SETUP.
//   CR, LF and space are ignored. Any other byte -> ERROR.
//  SETUP: 1 cycle, csoc_clk_o=0 (data setup). Then CLK_HI for HALF_PERIOD cycles (csoc_clk_o=1),
//   then CLK_LO for HALF_PERIOD cycles (csoc_clk_o=0).
//  Bit count: bit_cnt increments on the last CLK_LO cycle. If bit_cnt+1 == CSOC_NREGS -> IDLE,
//   se=0, done_o pulse; else -> LOAD_WAIT.
//  Latency: from the accepting strobe to the csoc_clk_o rising edge is 2 cycles.
//  RUN_HI/RUN_LO: HALF_PERIOD cycles each. clk_cnt increments at the end of RUN_LO. After RUN_CLKS
//   pulses -> IDLE, done_o pulse; tm stays 1.
//  Overrun: a strobe in SETUP/CLK_HI/CLK_LO/RUN_HI/RUN_LO -> ERROR immediately; csoc_clk_o forced 0.
//  ERROR: error_o=1, se=0, busy_o=0. A strobe with 'C' -> IDLE and error_o=0; all other bytes ignored.
//  Counter widths: bit_cnt is $clog2(CSOC_NREGS+1) bits; clk_cnt is $clog2(RUN_CLKS+1) bits;
//   neither ever wraps.
//  An 'L' or 'R' received while busy is data or overrun, never a command restart.
// CONFIGURATION
//  CSOC_SCAN_TIMEOUT_EN defined: counter of TIMEOUT_CYC cycles runs while in LOAD_WAIT and is
//   cleared by every strobe. Reaching TIMEOUT_CYC -> ERROR.
//  Not defined: LOAD_WAIT waits indefinitely; no timeout logic is synthesized.
// TESTING (CSOC_NREGS=4, RUN_CLKS=3, HALF_PERIOD=2, TIMEOUT_CYC=50)
//  T1 reset: rstn=0 for 2 cycles -> all outputs 0, busy_o=0.
//  T2 load: send "L1011\n" with gaps >=6 cycles -> 4 csoc_clk_o pulses; csoc_data_o[0] sampled at
//   the rising edges = 1,0,1,1; se=1 throughout the load; done_o pulses once; se=0 after.
//  T3 run: send 'R' -> exactly 3 pulses (2 high/2 low), se=0, tm=1, done_o pulse, busy_o=0 after.
//  T4 bad char: "L1x" -> ERROR after 'x', error_o=1, no further pulses; 'C' -> error_o=0, IDLE.
//  T5 overrun: "L1" then '0' strobed 1 cycle after the '1' -> ERROR, csoc_clk_o=0 on the next edge.
//  T6 macro on: "L1" then silence -> ERROR 50 cycles after entering LOAD_WAIT.
//   Macro off: same stimulus stays in LOAD_WAIT with busy_o=1.
//  T7 reset mid-CLK_HI -> csoc_clk_o=0 and state IDLE on the next edge.

Source files
------------

// File: rtl/csoc_scan_loader.sv
`default_nettype none
// ============================================================================
// Module   : csoc_scan_loader
// Purpose  : Decodes UART RX command bytes, shifts a host bit image into the
//            CSOC scan chain and issues functional run clocks.
//            Optional idle timeout in LOAD_WAIT: define CSOC_SCAN_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module csoc_scan_loader #(
    parameter int CSOC_NREGS  = 1919,
    parameter int RUN_CLKS    = 10,
    parameter int HALF_PERIOD = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    output logic       csoc_clk_o,
    output logic       csoc_test_se_o,
    output logic       csoc_test_tm_o,
    output logic [7:0] csoc_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    localparam int c_BIT_W = $clog2(CSOC_NREGS + 1);
    localparam int c_CLK_W = $clog2(RUN_CLKS + 1);
    localparam int c_PH_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(CSOC_NREGS - 1);
    localparam logic [c_CLK_W-1:0] c_CLK_LAST = c_CLK_W'(RUN_CLKS - 1);
    localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(HALF_PERIOD - 1);

    localparam logic [7:0] c_CH_L     = 8'h4C;
    localparam logic [7:0] c_CH_R     = 8'h52;
    localparam logic [7:0] c_CH_C     = 8'h43;
    localparam logic [7:0] c_CH_ZERO  = 8'h30;
    localparam logic [7:0] c_CH_ONE   = 8'h31;
    localparam logic [7:0] c_CH_CR    = 8'h0D;
    localparam logic [7:0] c_CH_LF    = 8'h0A;
    localparam logic [7:0] c_CH_SPACE = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_WAIT = 3'd1,
        S_SETUP     = 3'd2,
        S_CLK_HI    = 3'd3,
        S_CLK_LO    = 3'd4,
        S_RUN_HI    = 3'd5,
        S_RUN_LO    = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t             r_state;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_CLK_W-1:0] r_clk_cnt;
    logic [c_PH_W-1:0]  r_ph_cnt;

    logic w_is_bit;
    logic w_is_ws;
    logic w_clocking;
    logic w_overrun;
    logic w_bad_char;
    logic w_timeout;
    logic w_to_error;

    assign w_is_bit   = (rx_data == c_CH_ZERO) || (rx_data == c_CH_ONE);
    assign w_is_ws    = (rx_data == c_CH_CR) || (rx_data == c_CH_LF) || (rx_data == c_CH_SPACE);
    assign w_clocking = (r_state == S_SETUP)  || (r_state == S_CLK_HI) || (r_state == S_CLK_LO) ||
                        (r_state == S_RUN_HI) || (r_state == S_RUN_LO);
    assign w_overrun  = new_rx_data && w_clocking;
    assign w_bad_char = new_rx_data && (r_state == S_LOAD_WAIT) && !w_is_bit && !w_is_ws;
    assign w_to_error = w_overrun || w_bad_char || w_timeout;

`ifdef CSOC_SCAN_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    logic [c_TO_W-1:0] r_to_cnt;

    // Idle cycles spent waiting for the next bit character; any byte restarts it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_to_cnt <= '0;
        end else if ((r_state != S_LOAD_WAIT) || new_rx_data) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_TO_LAST) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_LOAD_WAIT) && !new_rx_data && (r_to_cnt == c_TO_LAST);
`else
    // TIMEOUT_CYC only matters for the timeout build; this folds to a constant 0.
    assign w_timeout = 1'b0 & (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_bit_cnt      <= '0;
            r_clk_cnt      <= '0;
            r_ph_cnt       <= '0;
            csoc_clk_o     <= 1'b0;
            csoc_test_se_o <= 1'b0;
            csoc_test_tm_o <= 1'b0;
            csoc_data_o    <= 8'h00;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (w_to_error) begin
                r_state        <= S_ERROR;
                csoc_clk_o     <= 1'b0;
                csoc_test_se_o <= 1'b0;
                busy_o         <= 1'b0;
                error_o        <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (new_rx_data && (rx_data == c_CH_L)) begin
                            r_state        <= S_LOAD_WAIT;
                            r_bit_cnt      <= '0;
                            csoc_test_se_o <= 1'b1;
                            csoc_test_tm_o <= 1'b1;
                            busy_o         <= 1'b1;
                        end else if (new_rx_data && (rx_data == c_CH_R)) begin
                            r_state        <= S_RUN_HI;
                            r_clk_cnt      <= '0;
                            r_ph_cnt       <= '0;
                            csoc_clk_o     <= 1'b1;
                            csoc_test_se_o <= 1'b0;
                            csoc_test_tm_o <= 1'b1;
                            busy_o         <= 1'b1;
                        end
                    end
                    S_LOAD_WAIT: begin
                        if (new_rx_data && w_is_bit) begin
                            r_state     <= S_SETUP;
                            csoc_data_o <= {7'b0, rx_data[0]};
                        end
                    end
                    S_SETUP: begin
                        r_state    <= S_CLK_HI;
                        r_ph_cnt   <= '0;
                        csoc_clk_o <= 1'b1;
                    end
                    S_CLK_HI: begin
                        if (r_ph_cnt == c_PH_LAST) begin
                            r_state    <= S_CLK_LO;
                            r_ph_cnt   <= '0;
                            csoc_clk_o <= 1'b0;
                        end else begin
                            r_ph_cnt <= r_ph_cnt + 1'b1;
                        end
                    end
                    S_CLK_LO: begin
                        if (r_ph_cnt == c_PH_LAST) begin
                            r_ph_cnt  <= '0;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_BIT_LAST) begin
                                r_state        <= S_IDLE;
                                csoc_test_se_o <= 1'b0;
                                busy_o         <= 1'b0;
                                done_o         <= 1'b1;
                            end else begin
                                r_state <= S_LOAD_WAIT;
                            end
                        end else begin
                            r_ph_cnt <= r_ph_cnt + 1'b1;
                        end
                    end
                    S_RUN_HI: begin
                        if (r_ph_cnt == c_PH_LAST) begin
                            r_state    <= S_RUN_LO;
                            r_ph_cnt   <= '0;
                            csoc_clk_o <= 1'b0;
                        end else begin
                            r_ph_cnt <= r_ph_cnt + 1'b1;
                        end
                    end
                    S_RUN_LO: begin
                        if (r_ph_cnt == c_PH_LAST) begin
                            r_ph_cnt  <= '0;
                            r_clk_cnt <= r_clk_cnt + 1'b1;
                            if (r_clk_cnt == c_CLK_LAST) begin
                                r_state <= S_IDLE;
                                busy_o  <= 1'b0;
                                done_o  <= 1'b1;
                            end else begin
                                r_state    <= S_RUN_HI;
                                csoc_clk_o <= 1'b1;
                            end
                        end else begin
                            r_ph_cnt <= r_ph_cnt + 1'b1;
                        end
                    end
                    S_ERROR: begin
                        if (new_rx_data && (rx_data == c_CH_C)) begin
                            r_state <= S_IDLE;
                            error_o <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
